// File: rtl/vga_timing_pkg.sv
// Shared VGA timing sets, pixel-format codes and the RGB565 expander.
package vga_timing_pkg;

    localparam int VGA640_H_SYNC  = 96;
    localparam int VGA640_H_BACK  = 48;
    localparam int VGA640_H_DISP  = 640;
    localparam int VGA640_H_FRONT = 16;
    localparam int VGA640_V_SYNC  = 2;
    localparam int VGA640_V_BACK  = 33;
    localparam int VGA640_V_DISP  = 480;
    localparam int VGA640_V_FRONT = 10;

    localparam int SVGA800_H_SYNC  = 120;
    localparam int SVGA800_H_BACK  = 64;
    localparam int SVGA800_H_DISP  = 800;
    localparam int SVGA800_H_FRONT = 56;
    localparam int SVGA800_V_SYNC  = 6;
    localparam int SVGA800_V_BACK  = 23;
    localparam int SVGA800_V_DISP  = 600;
    localparam int SVGA800_V_FRONT = 37;

    localparam int PIX_RGB565 = 16;
    localparam int PIX_RGB888 = 24;

    // MSB replication so that full-scale 565 maps to full-scale 888.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

endpackage

// File: rtl/vga_timing_gen_p_vga_sync_counter.sv
// Horizontal/vertical raster counters with run enable and line/frame pulse decode.
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int CNT_W   = 12
) (
    input  logic             vga_clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             line_pulse,
    output logic             frame_pulse
);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == CNT_W'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
        end
        // Held at the origin so that enabling starts a fresh frame.
        if (!en) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign line_pulse  = en && (h_cnt_q == '0);
    assign frame_pulse = line_pulse && (v_cnt_q == '0);

endmodule

// File: rtl/vga_timing_gen_p.sv
// Parametrised VGA timing generator with pixel prefetch and registered DAC outputs.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen_p
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC    = VGA640_H_SYNC,
    parameter int H_BACK    = VGA640_H_BACK,
    parameter int H_DISP    = VGA640_H_DISP,
    parameter int H_FRONT   = VGA640_H_FRONT,
    parameter int V_SYNC    = VGA640_V_SYNC,
    parameter int V_BACK    = VGA640_V_BACK,
    parameter int V_DISP    = VGA640_V_DISP,
    parameter int V_FRONT   = VGA640_V_FRONT,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int PIX_W     = PIX_RGB565,
    parameter int FETCH_LAT = 1,
    parameter int CNT_W     = 12
) (
    input  logic             vga_clk,
    input  logic             rst_n,
    input  logic             en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_sel,
`endif
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_xpos,
    output logic [CNT_W-1:0] pix_ypos,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_valid,
    output logic             underflow,
    input  logic             underflow_clr,
    output logic             line_start,
    output logic             frame_start,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             VGA_BLANK_N,
    output logic             VGA_SYNC_N,
    output logic [7:0]       VGA_R,
    output logic [7:0]       VGA_G,
    output logic [7:0]       VGA_B
);

    localparam int HA      = H_SYNC + H_BACK;
    localparam int VA      = V_SYNC + V_BACK;
    localparam int H_TOTAL = HA + H_DISP + H_FRONT;
    localparam int V_TOTAL = VA + V_DISP + V_FRONT;

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             line_pulse, frame_pulse;

    vga_sync_counter #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .CNT_W(CNT_W)) u_cnt (
        .vga_clk    (vga_clk),
        .rst_n      (rst_n),
        .en         (en),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .line_pulse (line_pulse),
        .frame_pulse(frame_pulse)
    );

    logic h_act, v_act, active, h_req;
    assign h_act  = (h_cnt >= CNT_W'(HA)) && (h_cnt < CNT_W'(HA + H_DISP));
    assign v_act  = (v_cnt >= CNT_W'(VA)) && (v_cnt < CNT_W'(VA + V_DISP));
    assign active = en && h_act && v_act;

    // Request window leads the active window by the source latency.
    assign h_req    = (h_cnt >= CNT_W'(HA - FETCH_LAT)) && (h_cnt < CNT_W'(HA + H_DISP - FETCH_LAT));
    assign pix_req  = en && h_req && v_act;
    assign pix_xpos = pix_req ? h_cnt - CNT_W'(HA - FETCH_LAT) : '0;
    assign pix_ypos = pix_req ? v_cnt - CNT_W'(VA) : '0;

    logic [23:0] pix_rgb;
    generate
        if (PIX_W == PIX_RGB888) begin : g_888
            assign pix_rgb = pix_data[23:0];
        end else begin : g_565
            assign pix_rgb = rgb565_to_888(pix_data[15:0]);
        end
    endgenerate

    logic        use_pat;
    logic [23:0] bar_rgb;
`ifdef VGA_TEST_PATTERN_EN
    logic [CNT_W-1:0] dcol, bar_idx;
    logic [2:0]       bar;
    always_comb begin
        dcol    = h_cnt - CNT_W'(HA);
        bar_idx = dcol / CNT_W'(H_DISP / 8);
        bar     = (bar_idx > CNT_W'(7)) ? 3'd7 : bar_idx[2:0];
        // white, yellow, cyan, green, magenta, red, blue, black
        bar_rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
        use_pat = test_sel;
    end
`else
    assign use_pat = 1'b0;
    assign bar_rgb = '0;
`endif

    logic [23:0] rgb_q, rgb_d;
    logic        hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic        line_q, frame_q, underflow_q, underflow_d;

    always_comb begin
        rgb_d = '0;
        if (active) begin
            if (use_pat)        rgb_d = bar_rgb;
            else if (pix_valid) rgb_d = pix_rgb;
        end
        underflow_d = underflow_q;
        if (underflow_clr) underflow_d = 1'b0;
        if (active && !use_pat && !pix_valid) underflow_d = 1'b1;
        hs_d      = (h_cnt < CNT_W'(H_SYNC)) ? 1'(HS_POL) : ~1'(HS_POL);
        vs_d      = (v_cnt < CNT_W'(V_SYNC)) ? 1'(VS_POL) : ~1'(VS_POL);
        blank_n_d = active;
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q       <= '0;
            hs_q        <= 1'(HS_POL);
            vs_q        <= 1'(VS_POL);
            blank_n_q   <= 1'b0;
            line_q      <= 1'b0;
            frame_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rgb_q       <= rgb_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_n_q   <= blank_n_d;
            line_q      <= line_pulse;
            frame_q     <= frame_pulse;
            underflow_q <= underflow_d;
        end
    end

    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign line_start  = line_q;
    assign frame_start = frame_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_timing_gen_p.sv
// Directed bench on reduced raster timings: A = RGB565, FETCH_LAT 2, active-low syncs;
// B = RGB888, FETCH_LAT 1, active-high syncs.  Raster 25 x 9, HA=7, VA=4, 16x4 visible.
module tb_vga_timing_gen_p;

    logic vga_clk = 1'b0;
    logic rst_n, en, drop, clr_a;
    logic clr_b = 1'b0;
    logic [15:0] src565;
    logic [23:0] src888 = 24'h123456;
`ifdef VGA_TEST_PATTERN_EN
    logic test_sel = 1'b0;
`endif

    logic        req_a, req_b, valid_a, valid_b;
    logic [11:0] xpos_a, ypos_a, xpos_b, ypos_b;
    logic        uf_a, uf_b, ls_a, ls_b, fs_a, fs_b, hs_a, hs_b, vs_a, vs_b;
    logic        bl_a, bl_b, sn_a, sn_b;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    always #5 vga_clk = ~vga_clk;

    // Pixel source stand-ins: return a pixel FETCH_LAT cycles after each request.
    logic [1:0] req_pipe_a = '0;
    logic       req_d_b    = 1'b0;
    always @(posedge vga_clk) begin
        req_pipe_a <= {req_pipe_a[0], req_a};
        req_d_b    <= req_b;
    end
    assign valid_a = req_pipe_a[1] & ~drop;
    assign valid_b = req_d_b;

    vga_timing_gen_p #(
        .H_SYNC(4), .H_BACK(3), .H_DISP(16), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
        .HS_POL(0), .VS_POL(0), .PIX_W(16), .FETCH_LAT(2), .CNT_W(12)
    ) u_dut_a (
        .vga_clk(vga_clk), .rst_n(rst_n), .en(en),
`ifdef VGA_TEST_PATTERN_EN
        .test_sel(test_sel),
`endif
        .pix_req(req_a), .pix_xpos(xpos_a), .pix_ypos(ypos_a),
        .pix_data(src565), .pix_valid(valid_a),
        .underflow(uf_a), .underflow_clr(clr_a),
        .line_start(ls_a), .frame_start(fs_a), .vga_hs(hs_a), .vga_vs(vs_a),
        .VGA_BLANK_N(bl_a), .VGA_SYNC_N(sn_a), .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a)
    );

    vga_timing_gen_p #(
        .H_SYNC(4), .H_BACK(3), .H_DISP(16), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
        .HS_POL(1), .VS_POL(1), .PIX_W(24), .FETCH_LAT(1), .CNT_W(12)
    ) u_dut_b (
        .vga_clk(vga_clk), .rst_n(rst_n), .en(en),
`ifdef VGA_TEST_PATTERN_EN
        .test_sel(test_sel),
`endif
        .pix_req(req_b), .pix_xpos(xpos_b), .pix_ypos(ypos_b),
        .pix_data(src888), .pix_valid(valid_b),
        .underflow(uf_b), .underflow_clr(clr_b),
        .line_start(ls_b), .frame_start(fs_b), .vga_hs(hs_b), .vga_vs(vs_b),
        .VGA_BLANK_N(bl_b), .VGA_SYNC_N(sn_b), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int e      = 0;   // clock edges since reset release / enable

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    // Registered outputs sampled at edge count E reflect raster position E-1.
    task automatic adv(input int n);
        if (n > 0) begin
            repeat (n) @(posedge vga_clk);
            @(negedge vga_clk);
            e += n;
        end
    endtask

    task automatic adv_to(input int t);
        adv(t - e);
    endtask

    int blank_cnt, quiet_cnt;

    initial begin
        rst_n = 1'b0; en = 1'b1; drop = 1'b0; clr_a = 1'b0; src565 = 16'hF800;
        repeat (3) @(negedge vga_clk);
        chk("rst_blank", bl_a, 1'b0);
        chk("rst_rgb", {r_a, g_a, b_a}, 24'h0);
        chk("rst_fs", fs_a, 1'b0);
        chk("rst_hs_a", hs_a, 1'b0);
        chk("rst_hs_b", hs_b, 1'b1);
        chk("rst_vs_b", vs_b, 1'b1);
        chk("sync_n", sn_a, 1'b0);

        rst_n = 1'b1; e = 0;
        adv(1);
        chk("fs_first", fs_a, 1'b1);
        chk("ls_first", ls_a, 1'b1);
        chk("vs_a_sync", vs_a, 1'b0);
        adv(1);
        chk("fs_once", fs_a, 1'b0);
        chk("ls_once", ls_a, 1'b0);
        adv_to(4);  chk("hs_a_last", hs_a, 1'b0);
        adv_to(5);  chk("hs_a_end", hs_a, 1'b1);
                    chk("hs_b_end", hs_b, 1'b0);
        adv_to(26); chk("ls_line1", ls_a, 1'b1);
                    chk("fs_line1", fs_a, 1'b0);
        adv_to(50); chk("vs_a_last", vs_a, 1'b0);
        adv_to(51); chk("vs_a_end", vs_a, 1'b1);
                    chk("vs_b_end", vs_b, 1'b0);

        // First active row (v=4): request window, blank width, RGB expansion.
        adv_to(100);
        blank_cnt = 0;
        for (int k = 101; k <= 125; k++) begin
            adv(1);
            if (bl_a) blank_cnt++;
            if (e == 104) chk("req_before", req_a, 1'b0);
            if (e == 105) begin
                chk("req_first", req_a, 1'b1);
                chk("xpos_first", xpos_a, 12'd0);
                chk("ypos_first", ypos_a, 12'd0);
            end
            if (e == 107) chk("blank_before", bl_a, 1'b0);
            if (e == 108) begin
                chk("rgb565_red", {r_a, g_a, b_a}, 24'hFF0000);
                chk("rgb888_pass", {r_b, g_b, b_b}, 24'h123456);
            end
            if (e == 120) begin
                chk("req_last", req_a, 1'b1);
                chk("xpos_last", xpos_a, 12'd15);
            end
            if (e == 121) chk("req_after", req_a, 1'b0);
            if (e == 123) chk("rgb_last_px", r_a, 8'hFF);
            if (e == 124) chk("rgb_blank", {r_a, g_a, b_a}, 24'h0);
        end
        chk("blank_width", blank_cnt, 16);

        adv_to(126); src565 = 16'h0841;
        adv_to(133); chk("rgb565_grey", {r_a, g_a, b_a}, 24'h080808);
        adv_to(150); chk("uf_a_clean", uf_a, 1'b0);
                     chk("uf_b_clean", uf_b, 1'b0);

        // Underflow: single drop, coincident clear, clean clear.
        adv_to(160); drop = 1'b1;
        adv(1);      drop = 1'b0;
        chk("drop_rgb", {r_a, g_a, b_a}, 24'h0);
        chk("drop_blank", bl_a, 1'b1);
        chk("uf_set", uf_a, 1'b1);
        adv(1);
        chk("after_drop_rgb", {r_a, g_a, b_a}, 24'h080808);
        chk("uf_sticky", uf_a, 1'b1);
        adv_to(165); drop = 1'b1; clr_a = 1'b1;
        adv(1);      drop = 1'b0;
        chk("uf_set_wins", uf_a, 1'b1);
        adv(1);      clr_a = 1'b0;
        chk("uf_cleared", uf_a, 1'b0);

        adv_to(225); chk("fs_period_pre", fs_a, 1'b0);
        adv_to(226); chk("fs_period", fs_a, 1'b1);
                     chk("uf_b_frame", uf_b, 1'b0);

        // Mid-frame asynchronous reset with a pending underflow.
        adv_to(335); drop = 1'b1;
        adv(1);      drop = 1'b0;
        chk("uf_pre_rst", uf_a, 1'b1);
        adv_to(340);
        chk("blank_pre_rst", bl_a, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_blank", bl_a, 1'b0);
        chk("arst_uf", uf_a, 1'b0);
        chk("arst_hs", hs_a, 1'b0);
        chk("arst_rgb", {r_a, g_a, b_a}, 24'h0);
        chk("arst_req", req_a, 1'b0);
        chk("arst_hs_b", hs_b, 1'b1);
        @(posedge vga_clk);
        @(negedge vga_clk);
        rst_n = 1'b1; e = 0;
        adv(1); chk("restart_fs", fs_a, 1'b1);
        adv(1); chk("restart_fs_off", fs_a, 1'b0);

        // Enable held low: no pulses, no active area, syncs at the origin level.
        adv_to(10);
        en = 1'b0;
        quiet_cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            adv(1);
            if (ls_a || fs_a || bl_a || req_a) quiet_cnt++;
        end
        chk("en_low_quiet", quiet_cnt, 0);
        chk("en_low_hs", hs_a, 1'b0);
        chk("en_low_vs", vs_a, 1'b0);
        en = 1'b1; e = 0;
        adv(1); chk("en_fs", fs_a, 1'b1);
        adv(1); chk("en_fs_off", fs_a, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
